// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: FSM states and byte-lane helpers.
// Lane numbering follows the byte address LSB; endianness maps it to bits.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  localparam logic LANE_0 = 1'b0;
  localparam logic LANE_1 = 1'b1;

  // True when the lane lives in bits [15:8].
  function automatic logic lane_hi(
    input logic big_endian,
    input logic lane
  );
    return (lane == LANE_0) ? big_endian : !big_endian;
  endfunction

endpackage

// File: rtl/mem_byte_fmt.sv
// Byte-lane formatter: load-side extract with sign/zero extension and
// store-side lane merge into a 16-bit word.
module mem_byte_fmt
  import mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [15:0] word,
  input  logic        lane,
  input  logic        sign,
  input  logic [7:0]  bdata,
  output logic [15:0] ld_data,
  output logic [15:0] st_data
);

  logic       hi;
  logic [7:0] sel;

  assign hi  = lane_hi(BIG_ENDIAN != 0, lane);
  assign sel = hi ? word[15:8] : word[7:0];

  assign ld_data = {{8{sign & sel[7]}}, sel};
  assign st_data = hi ? {bdata, word[7:0]}
                      : {word[15:8], bdata};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a 16-bit word memory.
// Byte stores run as read-modify-write over ACCESS then MERGE.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [15:0]       dm_wdata,
  output logic              dm_we,
  input  logic [15:0]       dm_rdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] h_addr;
  logic [15:0]       h_wdata;
  logic              h_write;
  logic              h_byte;
  logic              h_sign;
  logic [15:0]       merge_q;
  logic [15:0]       wdata_q;
  logic              misal;
  logic [15:0]       fmt_word;
  logic [15:0]       fmt_ld;
  logic [15:0]       fmt_st;

  assign misal   = !h_byte && h_addr[0];
  assign dm_addr = {1'b0, h_addr[ADDR_W-1:1]};

  // One formatter serves both the load path and the RMW merge.
  assign fmt_word = (state == MERGE) ? merge_q : dm_rdata;

  mem_byte_fmt #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_fmt (
    .word   (fmt_word),
    .lane   (h_addr[0]),
    .sign   (h_sign),
    .bdata  (h_wdata[7:0]),
    .ld_data(fmt_ld),
    .st_data(fmt_st)
  );

  always_comb begin
    state_nx  = state;
    dm_we     = 1'b0;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ACCESS;
      end
      ACCESS: begin
        dm_we    = h_write && !h_byte && !misal;
        state_nx = (h_write && h_byte) ? MERGE : IDLE;
      end
      MERGE: begin
        dm_we    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dm_wdata = wdata_q;
    if (state == MERGE) dm_wdata = fmt_st;
    else if (dm_we)     dm_wdata = h_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      h_addr    <= '0;
      h_wdata   <= '0;
      h_write   <= 1'b0;
      h_byte    <= 1'b0;
      h_sign    <= 1'b0;
      merge_q   <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (dm_we) wdata_q <= dm_wdata;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            h_addr  <= req_addr;
            h_wdata <= req_wdata;
            h_write <= req_write;
            h_byte  <= req_byte;
            h_sign  <= req_sign;
          end
        end
        ACCESS: begin
          if (misal) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (h_write && h_byte) begin
            merge_q <= dm_rdata;
          end else begin
            rsp_valid <= 1'b1;
            if (!h_write) rsp_rdata <= h_byte ? fmt_ld : dm_rdata;
          end
        end
        MERGE: rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word-memory model and a
// behavioural reference memory.
module tb_mem_access_unit;

  localparam int AW = 16;
  localparam int BE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_byte;
  logic          req_sign;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic [AW-1:0] dm_addr;
  logic [15:0]   dm_wdata;
  logic          dm_we;
  logic [15:0]   dm_rdata;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic          rsp_err;

  mem_access_unit #(.ADDR_W(AW), .BIG_ENDIAN(BE)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_byte (req_byte),
    .req_sign (req_sign),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [15:0] dm [0:32767];
  assign dm_rdata = dm[dm_addr[14:0]];
  always @(posedge clk) if (dm_we) dm[dm_addr[14:0]] <= dm_wdata;

  // Reference memory, updated at request acceptance.
  logic [15:0] ref_mem [0:32767];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  rsp_t exp_q[$];
  wr_t  wr_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rdata = '0;
  logic        last_err = 1'b0;
  logic        prev_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int shamt(input logic [15:0] a);
    if (BE != 0) return a[0] ? 0 : 8;
    return a[0] ? 8 : 0;
  endfunction

  task automatic model(input bit w, input bit b, input bit s,
                       input logic [15:0] a, input logic [15:0] wd);
    rsp_t        r;
    logic [14:0] wi;
    int          sh;
    logic [15:0] mask;
    logic [15:0] nw;
    logic [15:0] byt;
    wi = a[15:1];
    sh = shamt(a);
    r.cyc = cyc + 2;
    r.err = 1'b0;
    r.rdata = '0;
    if (!b && a[0]) begin
      r.err = 1'b1;
    end else if (w && !b) begin
      ref_mem[wi] = wd;
      wr_q.push_back('{cyc + 1, {1'b0, wi}, wd});
    end else if (w) begin
      mask = 16'h00FF << sh;
      nw = (ref_mem[wi] & ~mask) | ({8'h00, wd[7:0]} << sh);
      ref_mem[wi] = nw;
      r.cyc = cyc + 3;
      wr_q.push_back('{cyc + 2, {1'b0, wi}, nw});
    end else if (!b) begin
      r.rdata = ref_mem[wi];
    end else begin
      byt = (ref_mem[wi] >> sh) & 16'h00FF;
      r.rdata = (s && byt[7]) ? (16'hFF00 | byt) : byt;
    end
    exp_q.push_back(r);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit w, input bit b, input bit s,
                       input logic [15:0] a, input logic [15:0] wd,
                       output int acc);
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_sign  = s;
    req_addr  = a;
    req_wdata = wd;
    for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    model(w, b, s, a, wd);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: responses and memory writes against the queues.
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_extra", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("rsp_cycle", cyc, r.cyc);
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_rdata", rsp_rdata, r.rdata);
        end
        last_rdata <= rsp_rdata;
        last_err   <= rsp_err;
      end else if (prev_v) begin
        chk("rsp_clear", {rsp_err, rsp_rdata}, 0);
      end
      prev_v <= rsp_valid;
      if (dm_we) begin
        if (wr_q.size() == 0) begin
          chk("we_extra", 1, 0);
        end else begin
          w = wr_q.pop_front();
          chk("we_cycle", cyc, w.cyc);
          chk("dm_addr", dm_addr, w.addr);
          chk("dm_wdata", dm_wdata, w.data);
        end
      end
    end
  end

  initial begin
    int a0, a1, a2, a3;
    int acc[4];
    logic [15:0] old;
    logic [15:0] ra;
    for (int i = 0; i < 32768; i++) begin
      dm[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte = 1'b0;
    req_sign = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_we", dm_we, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1, 0, 0, 16'h0004, 16'hBEEF, a0);
    idle(0);
    issue(0, 0, 0, 16'h0004, 16'h0000, a0);
    idle(3);
    chk("word_ld", last_rdata, 16'hBEEF);

    issue(1, 0, 0, 16'h0004, 16'h1234, a0);
    issue(1, 1, 0, 16'h0005, 16'h00AB, a1);
    issue(0, 0, 0, 16'h0004, 16'h0000, a2);
    idle(3);
    chk("rmw_gap", a2 - a1, 3);
    chk("rmw_val", last_rdata, 16'h12AB);

    issue(1, 0, 0, 16'h0006, 16'hF07F, a0);
    issue(0, 1, 1, 16'h0006, 16'h0000, a0);
    idle(3);
    chk("ldb_s0", last_rdata, 16'hFFF0);
    issue(0, 1, 1, 16'h0007, 16'h0000, a0);
    idle(3);
    chk("ldb_s1", last_rdata, 16'h007F);
    issue(0, 1, 0, 16'h0006, 16'h0000, a0);
    idle(3);
    chk("ldb_z0", last_rdata, 16'h00F0);

    issue(1, 0, 0, 16'h0002, 16'h5A5A, a0);
    issue(1, 0, 0, 16'h0003, 16'h1111, a0);
    idle(3);
    chk("mis_err", last_err, 1);
    issue(0, 0, 0, 16'h0002, 16'h0000, a0);
    idle(3);
    chk("mis_keep", last_rdata, 16'h5A5A);

    issue(1, 0, 0, 16'h0010, 16'h0F0F, acc[0]);
    issue(0, 0, 0, 16'h0010, 16'h0000, acc[1]);
    issue(0, 0, 0, 16'h0004, 16'h0000, acc[2]);
    issue(1, 0, 0, 16'h0012, 16'hA5A5, acc[3]);
    idle(3);
    for (int i = 1; i < 4; i++) chk("b2b_gap", acc[i] - acc[i-1], 2);

    issue(1, 0, 0, 16'hFFFE, 16'hCAFE, a0);
    issue(0, 1, 0, 16'hFFFF, 16'h0000, a0);
    idle(3);
    chk("wrap_ld", last_rdata, 16'h00FE);

    old = ref_mem[2];
    issue(1, 1, 0, 16'h0004, 16'h0077, a3);
    req_valid = 1'b0;
    @(negedge clk);
    chk("merge_we", dm_we, 1);
    #2 rst = 1'b1;
    #1 chk("rst_we_drop", dm_we, 0);
    exp_q.delete();
    wr_q.delete();
    ref_mem[2] = old;
    @(negedge clk);
    chk("rst_no_rsp", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_ready2", req_ready, 1);
    @(negedge clk);
    issue(0, 0, 0, 16'h0004, 16'h0000, a0);
    idle(3);
    chk("rst_keep", last_rdata, 16'h12AB);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0)
        ra = 16'hFFFE | 16'($urandom_range(0, 1));
      else
        ra = 16'($urandom_range(0, 63));
      issue(1'($urandom), 1'($urandom), 1'($urandom), ra,
            16'($urandom), a0);
      idle($urandom_range(0, 2));
    end
    idle(0);
    for (int t = 0; t < 50 && (exp_q.size() != 0 || wr_q.size() != 0); t++)
      @(negedge clk);
    chk("drain_rsp", exp_q.size(), 0);
    chk("drain_wr", wr_q.size(), 0);
    for (int i = 0; i < 32; i++) chk("mem_word", dm[i], ref_mem[i]);
    chk("mem_wrap", dm[32767], ref_mem[32767]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
